// File: rtl/ping_scheduler.sv
// Round-robin ping scheduler: fires one ultrasonic channel at a time, latches its result, then holds a quiet gap.
// Optional per-sensor consecutive-miss counters are built when PING_STATS_EN is defined.
//
// state  | meaning
// IDLE   | not scheduling; waits for enable and a non-empty sensor_mask
// SELECT | samples sensor_mask and picks the next enabled sensor after last-served
// FIRE   | one-cycle start pulse to the selected sensor, arms the watchdog
// WAIT   | waits for new_measure / timeout of the selected sensor or watchdog expiry
// GAP    | quiet time before the next ping
module ping_scheduler #(
  parameter int N_SENSORS = 4,
  parameter int DIST_W    = 21,
  parameter int CLK_MHZ   = 50,
  parameter int GAP_MS    = 10,
  parameter int WDOG_MS   = 5
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic [N_SENSORS-1:0]        sensor_mask,
  output logic [N_SENSORS-1:0]        start,
  input  logic [N_SENSORS-1:0]        new_measure,
  input  logic [N_SENSORS-1:0]        timeout,
  input  logic [N_SENSORS*DIST_W-1:0] distance_raw,
  output logic [N_SENSORS*DIST_W-1:0] dist_out,
  output logic [N_SENSORS-1:0]        valid,
  output logic [N_SENSORS-1:0]        no_echo,
  output logic [N_SENSORS-1:0]        fault,
  output logic [2:0]                  cur_sensor,
  output logic                        busy,
  output logic                        sweep_done,
  output logic [N_SENSORS*8-1:0]      miss_count
);

  localparam int GAP_CYC  = CLK_MHZ * GAP_MS * 1000;
  localparam int WDOG_CYC = CLK_MHZ * WDOG_MS * 1000;
  localparam int TMR_MAX  = (GAP_CYC > WDOG_CYC) ? GAP_CYC : WDOG_CYC;
  localparam int TMR_W    = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] GAP_LOAD  = TMR_W'(GAP_CYC - 1);
  localparam logic [TMR_W-1:0] WDOG_LOAD = TMR_W'(WDOG_CYC - 1);

  typedef enum logic [2:0] {S_IDLE, S_SELECT, S_FIRE, S_WAIT, S_GAP} state_t;

  state_t               state;
  logic [2:0]           last_served;
  logic [N_SENSORS-1:0] mask_q;
  logic [TMR_W-1:0]     tmr;
  logic [2:0]           pick;
  logic                 pick_done;
  logic [2:0]           hi_idx;
  logic                 nm_cur;
  logic                 to_cur;
  logic [DIST_W-1:0]    dist_cur;

  // Scan offsets 1..N from last-served so a lone enabled sensor re-selects itself.
  always_comb begin
    pick      = '0;
    pick_done = 1'b0;
    for (int k = 1; k <= N_SENSORS; k++) begin
      for (int i = 0; i < N_SENSORS; i++) begin
        if (!pick_done && sensor_mask[i] && (i == (int'(last_served) + k) % N_SENSORS)) begin
          pick      = 3'(i);
          pick_done = 1'b1;
        end
      end
    end
  end

  always_comb begin
    hi_idx = '0;
    for (int i = 0; i < N_SENSORS; i++) begin
      if (mask_q[i]) hi_idx = 3'(i);
    end
  end

  always_comb begin
    nm_cur   = 1'b0;
    to_cur   = 1'b0;
    dist_cur = '0;
    for (int i = 0; i < N_SENSORS; i++) begin
      if (cur_sensor == 3'(i)) begin
        nm_cur   = new_measure[i];
        to_cur   = timeout[i];
        dist_cur = distance_raw[i*DIST_W +: DIST_W];
      end
    end
  end

  // One down-counter serves as watchdog in WAIT and gap timer in GAP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      start       <= '0;
      dist_out    <= '0;
      valid       <= '0;
      no_echo     <= '0;
      fault       <= '0;
      cur_sensor  <= '0;
      busy        <= 1'b0;
      sweep_done  <= 1'b0;
      last_served <= 3'(N_SENSORS - 1);
      mask_q      <= '0;
      tmr         <= '0;
    end else begin
      start      <= '0;
      sweep_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (enable && (|sensor_mask)) begin
            state <= S_SELECT;
            busy  <= 1'b1;
          end
        end
        S_SELECT: begin
          mask_q <= sensor_mask;
          if (|sensor_mask) begin
            cur_sensor <= pick;
            for (int i = 0; i < N_SENSORS; i++) start[i] <= (pick == 3'(i));
            state <= S_FIRE;
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        S_FIRE: begin
          tmr   <= WDOG_LOAD;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (nm_cur || to_cur || (tmr == '0)) begin
            for (int i = 0; i < N_SENSORS; i++) begin
              if (cur_sensor == 3'(i)) begin
                if (nm_cur) begin
                  dist_out[i*DIST_W +: DIST_W] <= dist_cur;
                  valid[i]   <= 1'b1;
                  no_echo[i] <= 1'b0;
                  fault[i]   <= 1'b0;
                end else if (to_cur) begin
                  valid[i]   <= 1'b0;
                  no_echo[i] <= 1'b1;
                  fault[i]   <= 1'b0;
                end else begin
                  valid[i]   <= 1'b0;
                  fault[i]   <= 1'b1;
                end
              end
            end
            tmr   <= GAP_LOAD;
            state <= S_GAP;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        S_GAP: begin
          if (tmr == '0) begin
            last_served <= cur_sensor;
            sweep_done  <= (cur_sensor == hi_idx);
            if (enable) begin
              state <= S_SELECT;
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef PING_STATS_EN
  // Consecutive failures per sensor; saturates, cleared by a good result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miss_count <= '0;
    end else if (state == S_WAIT) begin
      for (int i = 0; i < N_SENSORS; i++) begin
        if (cur_sensor == 3'(i)) begin
          if (nm_cur) begin
            miss_count[i*8 +: 8] <= 8'd0;
          end else if ((to_cur || (tmr == '0)) && (miss_count[i*8 +: 8] != 8'hFF)) begin
            miss_count[i*8 +: 8] <= miss_count[i*8 +: 8] + 8'd1;
          end
        end
      end
    end
  end
`else
  assign miss_count = '0;
`endif

endmodule

// File: doc/ping_scheduler.md
Name: ping_scheduler

Overview:
Round-robin scheduler for N ultrasonic ranging channels, each with its own ultrasonic instance, sharing one acoustic space.
- Fires one sensor at a time to avoid crosstalk.
- Waits for that sensor's result, then enforces a quiet gap before the next ping.
- Holds the latest distance and status per sensor.
- Replaces the free-running ping counter at top level.

Parameters:
N_SENSORS, 4, number of sensor channels (2..8)
DIST_W, 21, width of each distance_raw value
CLK_MHZ, 50, clock frequency in MHz
GAP_MS, 10, quiet time between consecutive pings; GAP_CYC = CLK_MHZ*GAP_MS*1000
WDOG_MS, 5, watchdog if the channel returns neither result nor timeout; WDOG_CYC = CLK_MHZ*WDOG_MS*1000

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  run scheduling when high
sensor_mask  in  N_SENSORS  per-sensor enable bits
start  out  N_SENSORS  one-cycle start pulse to each ultrasonic instance
new_measure  in  N_SENSORS  result-ready pulse from each instance
timeout  in  N_SENSORS  no-echo pulse from each instance
distance_raw  in  N_SENSORS*DIST_W  flattened live distances; sensor i at [i*DIST_W +: DIST_W]
dist_out  out  N_SENSORS*DIST_W  latched distances, same packing
valid  out  N_SENSORS  dist_out[i] holds a fresh good measurement
no_echo  out  N_SENSORS  last attempt on sensor i ended in timeout
fault  out  N_SENSORS  last attempt on sensor i hit the watchdog
cur_sensor  out  3  index of the sensor being served
busy  out  1  high in every state except IDLE
sweep_done  out  1  one-cycle pulse after serving the highest-index enabled sensor
miss_count  out  N_SENSORS*8  optional-feature counters (see below)

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0, including start, dist_out, valid, no_echo, fault, cur_sensor, busy, sweep_done and miss_count. Internal last-served index = N_SENSORS-1, so the first selection is sensor 0.
- States: IDLE, SELECT, FIRE, WAIT, GAP.
- IDLE: if enable=1 and sensor_mask!=0, go to SELECT next cycle.
- SELECT (1 cycle):
  - Sample sensor_mask.
  - Pick the lowest enabled index strictly greater than last-served, wrapping to 0; a single enabled sensor re-selects itself.
  - Load cur_sensor; go to FIRE.
  - If mask==0 at this point, go to IDLE.
- FIRE (1 cycle): start[cur_sensor]=1, all other start bits 0. Clear the watchdog counter; go to WAIT.
- WAIT: only bit cur_sensor of new_measure/timeout is observed; all other bits are ignored.
  - new_measure: dist_out[cur] <= distance_raw[cur] in the same cycle; valid[cur]<=1, no_echo[cur]<=0, fault[cur]<=0. Go to GAP.
  - timeout: valid[cur]<=0, no_echo[cur]<=1, fault[cur]<=0; dist_out[cur] unchanged. Go to GAP.
  - new_measure and timeout in the same cycle: new_measure wins.
  - Watchdog reaches WDOG_CYC-1 with neither event: fault[cur]<=1, valid[cur]<=0, no_echo unchanged. Go to GAP.
- GAP:
  - Count GAP_CYC cycles, starting at 0 on entry.
  - On the last count: if enable=1, go to SELECT, else IDLE. last-served <= cur_sensor.
  - sweep_done=1 on that exit cycle if cur_sensor is the highest set bit of the mask sampled in SELECT.
- Latency: start pulse asserts 2 cycles after leaving IDLE. Result latch is visible the cycle after new_measure. Minimum ping-to-ping spacing is 2+GAP_CYC cycles after the result.
- enable dropped mid-operation: the current FIRE/WAIT/GAP completes normally, then IDLE. start is never aborted.
- sensor_mask changed mid-operation: takes effect at the next SELECT. Clearing the bit of the sensor being served does not abort it.
- The watchdog and gap counters are wide enough for WDOG_CYC and GAP_CYC with no wrap.

Optional Feature:
PING_STATS_EN:
- Defined: miss_count[i] is an 8-bit counter of consecutive failed attempts on sensor i. A failed attempt is a timeout or watchdog expiry.
- It saturates at 255 and clears to 0 on new_measure for sensor i.
- Not defined: miss_count is driven constant 0 and no counter logic is built.

Test Plan:
- Sim params CLK_MHZ=1, GAP_MS=1 (GAP_CYC=1000), WDOG_MS=1; mask=4'b1011, enable=1. Expect start pulses in order sensor 0,1,3,0, each 1 cycle wide. sweep_done pulses after sensor 3.
- Sensor 1 pulses new_measure with distance_raw=58000 -> dist_out[1]=58000, valid[1]=1, no_echo[1]=0. The next start comes exactly GAP_CYC+2 cycles after the pulse.
- Sensor 0 asserts timeout and new_measure in the same cycle with distance 1234 -> new_measure wins: valid[0]=1, dist_out[0]=1234.
- Sensor 3 silent -> fault[3]=1 after 1000 WAIT cycles. With PING_STATS_EN, three silent rounds give miss_count[3]=3; one good result then gives 0.
- Stray new_measure[2] while serving sensor 1 -> ignored; dist_out[2] and valid[2] unchanged.
- Drop enable during WAIT -> the result is still latched and GAP runs, then IDLE with busy=0. rst_n low mid-WAIT -> all outputs 0 immediately, without waiting for a clock edge.
